// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: data widths, opcode values,
// the fetch FSM state type, and an opcode extraction helper.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_BEQ = 4'hC,
    OP_JMP = 4'hD,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DROP,
    ST_HALT
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its fetch address
// while decode is stalled.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_word,
  input  logic [ADDR_W-1:0]  load_addr,
  output logic               valid,
  output logic [INSTR_W-1:0] word,
  output logic [ADDR_W-1:0]  addr
);

  // Clear wins so a flush can never leave a stale wrong-path word behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      word  <= '0;
      addr  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
      addr  <= load_addr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the imem handshake, loads IF/ID, pulses
// pc_advance, absorbs decode stalls, drops wrong-path fetches and stops on HLT.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [3:0]        HLT_OPCODE = OP_HLT,
  parameter logic [ADDR_W-1:0] PC_INC     = 16'd2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  fetch_stage_if.master      imem,
  input  logic               id_stall,
  input  logic               flush,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               halted
);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               accept;
  logic               park;
  logic               drain;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_word;
  logic [ADDR_W-1:0]  skid_addr;
  logic [ADDR_W-1:0]  src_addr;
  logic [ADDR_W-1:0]  src_plus2;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (park),
    .clear     (flush || drain),
    .load_word (imem.imem_data),
    .load_addr (fetch_addr),
    .valid     (skid_valid),
    .word      (skid_word),
    .addr      (skid_addr)
  );

  // In FETCH the address follows pc; once a request is outstanding it is frozen.
  always_comb begin
    fetch_addr = (state == ST_FETCH) ? pc : addr_q;
    src_addr   = drain ? skid_addr : fetch_addr;
    src_plus2  = src_addr + PC_INC;
  end

  always_comb begin
    accept = 1'b0;
    park   = 1'b0;
    drain  = 1'b0;
    case (state)
      ST_FETCH, ST_WAIT: begin
        accept = imem.imem_ready && !id_stall && !flush;
        park   = imem.imem_ready &&  id_stall && !flush;
      end
      ST_HOLD: drain = skid_valid && !id_stall && !flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_FETCH;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH) addr_q <= pc;
    end
  end

  // A flush with no response yet in WAIT must still swallow that late response.
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH, ST_WAIT: begin
        if (flush)
          state_next = (state == ST_WAIT && !imem.imem_ready) ? ST_DROP : ST_FETCH;
        else if (accept)
          state_next = (opcode_of(imem.imem_data) == HLT_OPCODE) ? ST_HALT : ST_FETCH;
        else if (park)
          state_next = ST_HOLD;
        else
          state_next = ST_WAIT;
      end
      ST_HOLD: begin
        if (flush)
          state_next = ST_FETCH;
        else if (drain)
          state_next = (opcode_of(skid_word) == HLT_OPCODE) ? ST_HALT : ST_FETCH;
      end
      ST_DROP: if (imem.imem_ready) state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Request and advance are gated by rst so they are quiet while reset is held.
  always_comb begin
    imem.imem_addr = fetch_addr;
    imem.imem_req  = 1'b0;
    case (state)
      ST_FETCH, ST_WAIT, ST_DROP: imem.imem_req = rst;
      default: ;
    endcase
    pc_advance = rst && (accept || drain);
    halted     = (state == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc_plus2 <= '0;
    end else if (flush && state != ST_HALT) begin
      if_id_valid <= 1'b0;
    end else if (accept) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= imem.imem_data;
      if_id_pc_plus2 <= src_plus2;
    end else if (drain) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= skid_word;
      if_id_pc_plus2 <= src_plus2;
    end else if (!id_stall) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule
